// File: rtl/lc330_pkg.sv
// lc330_pkg: shared constants and types for the multi-cycle LC330 core.
//   - instruction field positions and widths (opcode, regA, regB, dest, offset)
//   - opcode encodings
//   - FSM state enumeration
//   - a small helper for pulling 3-bit register specifiers out of the IR
package lc330_pkg;

    localparam int OFF_W    = 16;          // immediate offset width
    localparam int REG_W    = 3;           // register specifier width
    localparam int NUM_REGS = 1 << REG_W;  // architectural registers
    localparam int OPC_W    = 3;
    localparam int IR_W     = 25;          // instruction bits that carry meaning

    // Field LSB positions inside the instruction word
    localparam int OPC_LSB  = 22;
    localparam int RA_LSB   = 19;
    localparam int RB_LSB   = 16;
    localparam int RD_LSB   = 0;
    localparam int OFF_LSB  = 0;

    localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OPC_W-1:0] OP_NAND = 3'b001;
    localparam logic [OPC_W-1:0] OP_LW   = 3'b010;
    localparam logic [OPC_W-1:0] OP_SW   = 3'b011;
    localparam logic [OPC_W-1:0] OP_BEQ  = 3'b100;
    localparam logic [OPC_W-1:0] OP_JALR = 3'b101;
    localparam logic [OPC_W-1:0] OP_HALT = 3'b110;
    localparam logic [OPC_W-1:0] OP_NOOP = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    function automatic logic [REG_W-1:0] reg_field(input logic [IR_W-1:0] ir, input int lsb);
        return ir[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/lc330_regfile.sv
// lc330_regfile: 8 x XLEN register file, r0 hardwired to zero.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears all entries)
//   raddr_a_i/_b_i      read addresses (asynchronous read)
//   rdata_a_o/_b_o      read data
//   we_i, waddr_i,      synchronous write port; writes to r0 are discarded
//   wdata_i
module lc330_regfile
    import lc330_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] raddr_a_i,
    input  logic [REG_W-1:0] raddr_b_i,
    output logic [XLEN-1:0]  rdata_a_o,
    output logic [XLEN-1:0]  rdata_b_o,
    input  logic             we_i,
    input  logic [REG_W-1:0] waddr_i,
    input  logic [XLEN-1:0]  wdata_i
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/lc330_multicycle.sv
// lc330_multicycle: multi-cycle LC330 core. One memory transaction per FSM
// state against a unified instruction/data memory with a req/ack handshake.
//
// Parameters: XLEN (datapath width, >= 25), MEM_AW (word-address width),
//             RESET_PC (PC after reset).
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   mem_req      memory request valid (forced low while rst is asserted)
//   mem_we       1 = write, 0 = read
//   mem_addr     word address
//   mem_wdata    store data
//   mem_rdata    read data, valid with mem_ack
//   mem_ack      completes the transaction on a rising edge with mem_req
//   halted       core has executed HALT
//   instret      retired-instruction count (wraps)
//
// Build option: define LC330_JALR_EN to execute opcode 101 as jalr;
// otherwise it retires as a noop.
module lc330_multicycle
    import lc330_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 16,
    parameter logic [MEM_AW-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [31:0]       instret
);

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] pc_q;
    logic [IR_W-1:0]   ir_q;
    logic [XLEN-1:0]   a_q, b_q, alu_q, mdr_q;
    logic [31:0]       instret_q;

    logic [OPC_W-1:0]  opc;
    logic [REG_W-1:0]  ra, rb, rd;
    logic [OFF_W-1:0]  off;
    logic signed [XLEN-1:0] off_sx;
    logic [XLEN-1:0]   alu_d;
    logic [MEM_AW-1:0] br_tgt;
    logic              take_br;
    logic              mem_fire;
    logic              retire;

    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [XLEN-1:0]   rf_wdata, rf_a, rf_b;

    assign opc    = ir_q[OPC_LSB +: OPC_W];
    assign ra     = reg_field(ir_q, RA_LSB);
    assign rb     = reg_field(ir_q, RB_LSB);
    assign rd     = reg_field(ir_q, RD_LSB);
    assign off    = ir_q[OFF_LSB +: OFF_W];
    assign off_sx = {{(XLEN-OFF_W){off[OFF_W-1]}}, off};

    // PC has already been incremented in FETCH, so this is PC+1+off.
    assign br_tgt  = pc_q + off_sx[MEM_AW-1:0];
    assign take_br = (opc == OP_BEQ) && (a_q == b_q);
    assign mem_fire = mem_req && mem_ack;

    lc330_regfile #(.XLEN(XLEN)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .raddr_a_i (ra),
        .raddr_b_i (rb),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata)
    );

    always_comb begin
        alu_d = a_q + b_q;
        case (opc)
            OP_NAND:      alu_d = ~(a_q & b_q);
            OP_LW, OP_SW: alu_d = a_q + off_sx;
            default:      ;
        endcase
    end

    // Register-file write: results in WB, plus the jalr link in EXEC.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = alu_q;
        if (state_q == ST_WB) begin
            rf_we = 1'b1;
            if (opc == OP_LW) begin
                rf_waddr = rb;
                rf_wdata = mdr_q;
            end
        end
`ifdef LC330_JALR_EN
        if ((state_q == ST_EXEC) && (opc == OP_JALR)) begin
            rf_we    = 1'b1;
            rf_waddr = rb;
            rf_wdata = XLEN'(pc_q);
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_fire) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (opc)
                    OP_HALT: state_d = ST_HALT;
                    OP_NOOP: state_d = ST_FETCH;
`ifndef LC330_JALR_EN
                    OP_JALR: state_d = ST_FETCH;
`endif
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (opc)
                    OP_ADD, OP_NAND: state_d = ST_WB;
                    OP_LW, OP_SW:    state_d = ST_MEM;
                    default:         state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_fire) state_d = (opc == OP_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // FSM outputs. mem_req is gated by rst so it drops the moment reset hits.
    always_comb begin
        mem_req   = !rst && ((state_q == ST_FETCH) || (state_q == ST_MEM));
        mem_we    = (state_q == ST_MEM) && (opc == OP_SW);
        mem_addr  = (state_q == ST_MEM) ? alu_q[MEM_AW-1:0] : pc_q;
        mem_wdata = b_q;
        halted    = (state_q == ST_HALT);
    end

    // An instruction retires on its last transition back to FETCH, or into HALT.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            ST_DECODE:              retire = (state_d == ST_FETCH) || (state_d == ST_HALT);
            ST_EXEC, ST_MEM, ST_WB: retire = (state_d == ST_FETCH);
            default:                ;
        endcase
    end

    // Datapath latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            instret_q <= '0;
        end else begin
            if (retire) instret_q <= instret_q + 32'd1;
            case (state_q)
                ST_FETCH: begin
                    if (mem_fire) begin
                        ir_q <= mem_rdata[IR_W-1:0];
                        pc_q <= pc_q + MEM_AW'(1);
                    end
                end
                ST_DECODE: begin
                    a_q <= rf_a;
                    b_q <= rf_b;
                end
                ST_EXEC: begin
                    alu_q <= alu_d;
                    if (take_br) pc_q <= br_tgt;
`ifdef LC330_JALR_EN
                    // A was latched in DECODE, so ra==rb still jumps to the old A.
                    if (opc == OP_JALR) pc_q <= a_q[MEM_AW-1:0];
`endif
                end
                ST_MEM: begin
                    if (mem_fire && (opc == OP_LW)) mdr_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_lc330_multicycle.sv
module tb_lc330_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ack, halted;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, instret;

    // Second core with a 4-bit address space for PC-wrap cases
    logic        rst2;
    logic        s_req, s_we, s_halted;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata, s_rdata, s_instret;

    logic [31:0] mem  [256];
    logic [31:0] smem [16];

    int          wait_n = 0;
    int          wcnt   = 0;
    int          wr_cnt = 0;
    logic [15:0] wlog_addr [16];
    logic [31:0] wlog_data [16];
    int          stab_err = 0;
    logic        pend = 1'b0;
    logic [15:0] p_addr;
    logic        p_we;
    logic [31:0] p_wdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lc330_multicycle #(.XLEN(32), .MEM_AW(16), .RESET_PC(16'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .instret   (instret)
    );

    lc330_multicycle #(.XLEN(32), .MEM_AW(4), .RESET_PC(4'd0)) dut_s (
        .clk       (clk),
        .rst       (rst2),
        .mem_req   (s_req),
        .mem_we    (s_we),
        .mem_addr  (s_addr),
        .mem_wdata (s_wdata),
        .mem_rdata (s_rdata),
        .mem_ack   (1'b1),
        .halted    (s_halted),
        .instret   (s_instret)
    );

    // Memory model: ack after wait_n wait cycles, writes are logged.
    assign mem_ack   = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr[7:0]];
    assign s_rdata   = smem[s_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
        if (mem_req && mem_we && mem_ack) begin
            wlog_addr[wr_cnt % 16] <= mem_addr;
            wlog_data[wr_cnt % 16] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (mem_req) begin
            if (pend && ((mem_addr != p_addr) || (mem_we != p_we) ||
                         (mem_we && (mem_wdata != p_wdata))))
                stab_err <= stab_err + 1;
            pend    <= !mem_ack;
            p_addr  <= mem_addr;
            p_we    <= mem_we;
            p_wdata <= mem_wdata;
        end else begin
            pend <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [15:0] off);
        return {7'b0, op, a, b, off};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = enc(3'd6, 3'd0, 3'd0, 16'd0);
    endtask

    task automatic start(input int w);
        rst    = 1'b1;
        wait_n = w;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input int max_cyc, output int cyc);
        cyc = 0;
        while (!halted && (cyc < max_cyc)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    task automatic small_start();
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0] = enc(3'd0, 3'd0, 3'd0, 16'd1);  // add r1 = r0 + r0
        mem[1] = enc(3'd2, 3'd0, 3'd2, 16'd5);  // lw  r2, r0, 5
        mem[2] = enc(3'd0, 3'd2, 3'd2, 16'd3);  // add r3 = r2 + r2
        mem[3] = enc(3'd6, 3'd0, 3'd0, 16'd0);  // halt
        mem[5] = 32'd7;
    endtask

    initial begin
        int cyc;
        int base;
        logic found;

        rst  = 1'b1;
        rst2 = 1'b1;
        load_prog1();
        for (int i = 0; i < 16; i++) smem[i] = enc(3'd7, 3'd0, 3'd0, 16'd0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_instret", instret, 32'd0);
        check("rst_addr", mem_addr, 16'd0);

        // Program 1, zero-wait memory
        rst = 1'b0;
        #1;
        check("first_req", mem_req, 1'b1);
        check("first_we", mem_we, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        check("halt_not_c14", halted, 1'b0);
        @(posedge clk);
        #1;
        check("halt_at_c15", halted, 1'b1);
        check("p1_r3", dut.u_rf.regs_q[3], 32'd14);
        check("p1_r2", dut.u_rf.regs_q[2], 32'd7);
        check("p1_instret", instret, 32'd4);
        check("p1_halt_noreq", mem_req, 1'b0);

        // Program 1, three wait cycles per transaction
        start(3);
        run_to_halt(200, cyc);
        check("p1w_cycles", cyc, 30);
        check("p1w_r3", dut.u_rf.regs_q[3], 32'd14);
        check("p1w_instret", instret, 32'd4);
        check("p1w_stable", stab_err, 0);

        // Stores, including r0 as a discarded destination
        clear_mem();
        mem[0]  = enc(3'd2, 3'd0, 3'd1, 16'd20); // lw  r1, r0, 20
        mem[1]  = enc(3'd3, 3'd0, 3'd1, 16'd9);  // sw  r1 -> mem[r0+9]
        mem[2]  = enc(3'd0, 3'd1, 3'd1, 16'd0);  // add r0 = r1 + r1
        mem[3]  = enc(3'd3, 3'd0, 3'd0, 16'd10); // sw  r0 -> mem[r0+10]
        mem[20] = 32'h0000_DEAD;
        base = wr_cnt;
        start(0);
        run_to_halt(100, cyc);
        check("sw_count", wr_cnt - base, 2);
        check("sw_addr", wlog_addr[base % 16], 16'd9);
        check("sw_data", wlog_data[base % 16], 32'h0000_DEAD);
        check("r0_addr", wlog_addr[(base + 1) % 16], 16'd10);
        check("r0_data", wlog_data[(base + 1) % 16], 32'd0);
        check("sw_instret", instret, 32'd5);

        // Reset during a pending store
        clear_mem();
        mem[0] = enc(3'd3, 3'd0, 3'd0, 16'd9);
        start(3);
        base  = wr_cnt;
        found = 1'b0;
        for (int i = 0; (i < 40) && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) found = 1'b1;
        end
        check("pend_sw_seen", found, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_drops_req", mem_req, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_no_write", wr_cnt - base, 0);
        rst = 1'b0;
        #1;
        check("rst_refetch_req", mem_req, 1'b1);
        check("rst_refetch_addr", mem_addr, 16'd0);
        check("rst_refetch_we", mem_we, 1'b0);
        check("rst_instret", instret, 32'd0);

        // jalr, nand and a not-taken beq
        clear_mem();
        mem[0]  = enc(3'd2, 3'd0, 3'd4, 16'd30); // lw   r4, r0, 30
        mem[1]  = enc(3'd1, 3'd4, 3'd4, 16'd2);  // nand r2 = r4, r4
        mem[2]  = enc(3'd4, 3'd4, 3'd0, 16'd7);  // beq  r4, r0 (not taken)
        mem[3]  = enc(3'd5, 3'd4, 3'd5, 16'd0);  // jalr r4, r5
        mem[30] = 32'd20;
        start(0);
        run_to_halt(100, cyc);
        check("nand_r2", dut.u_rf.regs_q[2], 32'hFFFF_FFEB);
        check("jalr_r4", dut.u_rf.regs_q[4], 32'd20);
        check("jalr_instret", instret, 32'd5);
`ifdef LC330_JALR_EN
        check("jalr_r5", dut.u_rf.regs_q[5], 32'd4);
        check("jalr_pc", dut.pc_q, 16'd21);
`else
        check("jalr_r5", dut.u_rf.regs_q[5], 32'd0);
        check("jalr_pc", dut.pc_q, 16'd5);
`endif

        // 4-bit PC: beq -1 from 0 loops on 0
        smem[0] = enc(3'd4, 3'd0, 3'd0, 16'hFFFF);
        small_start();
        repeat (3) @(posedge clk);
        #1;
        check("beqm1_addr", s_addr, 4'd0);
        check("beqm1_req", s_req, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("beqm1_addr2", s_addr, 4'd0);
        check("beqm1_instret", s_instret, 32'd2);

        // beq +15 from 0 wraps to 0
        smem[0] = enc(3'd4, 3'd0, 3'd0, 16'd15);
        small_start();
        repeat (3) @(posedge clk);
        #1;
        check("beq15_addr", s_addr, 4'd0);
        check("beq15_instret", s_instret, 32'd1);

        // beq +14 lands on 15; PC increment past 15 wraps to 0
        smem[0] = enc(3'd4, 3'd0, 3'd0, 16'd14);
        small_start();
        repeat (3) @(posedge clk);
        #1;
        check("beq14_addr", s_addr, 4'd15);
        repeat (2) @(posedge clk);
        #1;
        check("pcwrap_addr", s_addr, 4'd0);
        check("pcwrap_instret", s_instret, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lc330_multicycle.md
# lc330_multicycle

Multi-cycle LC330 core: executes the LC330 ISA over a state machine, one memory transaction per state, against a single unified instruction/data memory reached through a req/ack handshake. It replaces the single-cycle core in systems where memory has variable latency or where data width and address space must be configured. It adds a HALT state, a retired-instruction counter and configurable widths.

## Interface
- XLEN, 32: datapath/register width; must be >= 25.
- MEM_AW, 16: word-address width of memory and PC.
- RESET_PC, 0: PC value loaded on reset.
- clk  input  1  clock.
- rst  input  1  reset: asynchronous, active-high.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  MEM_AW  word address.
- mem_wdata  output  XLEN  store data.
- mem_rdata  input  XLEN  read data; valid in the cycle mem_ack=1.
- mem_ack  input  1  transaction completes on a rising edge with mem_req&&mem_ack.
- halted  output  1  core has executed HALT.
- instret  output  32  retired-instruction count; wraps at 2^32.

## Operation
- Encoding: opcode [24:22], regA [21:19], regB [18:16], dest [2:0], offset [15:0] sign-extended to XLEN. Bits above 24 ignored.
- Opcodes: 000 add (dest=A+B), 001 nand (dest=~(A&B)), 010 lw (B=mem[A+off]), 011 sw (mem[A+off]=B), 100 beq (if A==B, PC=PC+1+off), 101 jalr, 110 halt, 111 noop.
- Registers: 8 x XLEN; r0 reads 0, writes discarded.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, we=0, addr=PC; on ack latch IR, PC<=PC+1 → DECODE.
- DECODE: read A, B into latches → EXEC; halt → HALT; noop → FETCH.
- EXEC: ALU result into latch. add/nand → WB; lw/sw → MEM; beq: load PC on taken, → FETCH; jalr → FETCH.
- MEM: mem_req=1, addr=ALU[MEM_AW-1:0]; lw latches rdata → WB on ack; sw writes B → FETCH on ack.
- WB: write regfile → FETCH.
- HALT: absorbing; mem_req=0, halted=1; only rst leaves.
- instret increments on each transition out of EXEC, MEM or WB that returns to FETCH, on DECODE→FETCH for noop, and on DECODE→HALT.
- Arithmetic is modulo 2^XLEN. PC and branch targets are modulo 2^MEM_AW, and wrap silently.
- mem_addr, mem_we and mem_wdata are held stable while mem_req=1 and no ack has arrived. mem_ack with mem_req=0 is ignored.
- Unknown states → FETCH.

## Timing
- Reset: PC=RESET_PC, state=FETCH, all registers 0, IR=0, instret=0, mem_req=0 while rst is asserted, halted=0. mem_req rises in the first cycle after rst deasserts.
- Zero-wait memory (ack in the same cycle as req), cycles per instruction: add/nand 4, lw 5, sw 4, beq/jalr 3, noop 2, halt 2 to reach HALT. Each wait cycle adds 1.
- rst mid-transaction: mem_req drops immediately (asynchronous reset). Any pending write is abandoned and no architectural state is updated.
- Regfile write occurs on the clock edge that leaves WB. A read in the next DECODE sees the new value.

## Configuration
- LC330_JALR_EN defined: opcode 101 executes jalr: B=PC+1 (already incremented PC), then PC=A[MEM_AW-1:0]. If A and B name the same register, PC takes the old A and B receives the link.
- LC330_JALR_EN undefined: opcode 101 executes as noop (2 cycles) and is still counted in instret.

## Structure
- lc330_pkg: opcode constants, state enum, field bit positions, and the OFF_W=16 and REG_W=3 constants.
- Sub-module lc330_regfile: 8 x XLEN, 2 asynchronous read ports, 1 synchronous write port, r0 hardwired to 0, asynchronous reset to 0.
- The top level holds the FSM, PC, IR, A/B/ALU latches, the MDR and instret.

## Test plan
- Zero-wait memory, program `add r1=r0+r0`, `lw r2,r0,5` with mem[5]=7, `add r3=r2+r2`, halt → r3=14, halted=1 at cycle 15, instret=4.
- Memory acks after 3 wait cycles on every transaction, same program → identical final state, and mem_addr/mem_we are stable throughout each request.
- beq r0,r0,-1 at address 0, MEM_AW=4 → PC wraps correctly; in a separate case, offset 15 from PC 0 → target 0 (mod 16).
- sw r0,r1,9 with r1=0xDEAD → one write: mem_addr=9, mem_wdata=0xDEAD, mem_we=1. An instruction writing r0 leaves r0 reading 0.
- Assert rst during a pending sw → mem_req=0 in the same cycle and no write occurs. After release, fetch restarts at RESET_PC with instret=0.
- With LC330_JALR_EN, jalr A=r4 (r4=20), B=r5 at PC 3 → r5=4, next fetch from 20. Without LC330_JALR_EN → r5 unchanged, next fetch from 4.
